// File: rtl/coeff_bank_fir.sv
// -----------------------------------------------------------------------------
// coeff_bank_fir
//
// Single-MAC FIR filter with double-buffered coefficient banks. A new
// coefficient set streams into the shadow bank while the filter keeps running
// on the active bank. The banks swap only between samples, so a result is never
// computed from a mix of old and new coefficients.
//
// Each accepted sample takes NTAPS MAC cycles, one ROUND cycle and one OUT
// cycle. out_valid rises NTAPS+2 cycles after the input handshake, and the next
// sample can be taken one cycle later (one sample per NTAPS+3 cycles).
//
// Parameters
//   NTAPS : taps per bank (coefficient words per set)
//   DW    : sample / coefficient width, signed Q1.15 for DW=16
//   ACCW  : accumulator width
//
// Ports
//   clk, rst_n            : clock; asynchronous active-low reset. Deassertion is
//                           synchronised to clk internally.
//   coef_valid/data/last  : coefficient stream, tap 0 first; last marks tap NTAPS-1
//   coef_ready            : low while a completed set waits for its bank swap
//   coef_err              : one-cycle pulse on a malformed set (bad coef_last position)
//   in_valid/in_data      : input sample
//   in_ready              : high only when idle and no swap is pending
//   out_valid/out_data    : one-cycle result pulse, saturated to DW bits
//   bank_sel              : index of the active coefficient bank
// -----------------------------------------------------------------------------
module coeff_bank_fir #(
  parameter int NTAPS = 101,
  parameter int DW    = 16,
  parameter int ACCW  = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coef_valid,
  input  logic [DW-1:0] coef_data,
  input  logic          coef_last,
  output logic          coef_ready,
  output logic          coef_err,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          bank_sel
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NTAPS - 1);

  // Rounding bias 2^(DW-2) and the saturation limits of a signed DW-bit result.
  localparam logic signed [ACCW-1:0] RND_BIAS =
    {{(ACCW-DW+1){1'b0}}, 1'b1, {(DW-2){1'b0}}};
  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN =
    {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t state, state_nxt;

  // Reset synchroniser. Assertion is asynchronous and release waits two clock
  // edges, so every flop below leaves reset on the same clock edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // Storage
  logic signed [DW-1:0] bank0 [NTAPS];
  logic signed [DW-1:0] bank1 [NTAPS];
  logic signed [DW-1:0] dline [NTAPS];

  logic                   swap_pending;
  logic [IW-1:0]          ld_idx;
  logic [IW-1:0]          wr_ptr;
  logic [IW-1:0]          rd_ptr;
  logic [IW-1:0]          tap;
  logic signed [ACCW-1:0] acc;

  // Handshakes and load-sequence decode
  logic coef_hs, in_hs, at_last, coef_bad, coef_done, do_swap;

  assign coef_ready = !swap_pending;
  assign in_ready   = (state == IDLE) && !swap_pending;
  assign coef_hs    = coef_valid && coef_ready;
  assign in_hs      = in_valid && in_ready;
  assign at_last    = (ld_idx == LAST);
  // A set is malformed when coef_last does not line up with tap NTAPS-1.
  assign coef_bad   = coef_hs && (coef_last != at_last);
  assign coef_done  = coef_hs && coef_last && at_last;
  // The swap happens only between samples, so the active bank stays fixed
  // through MAC, ROUND and OUT.
  assign do_swap    = (state == IDLE) && swap_pending;

  // MAC datapath: coefficient k of the active bank times the sample written
  // k samples ago. rd_ptr walks backwards from the newest sample.
  logic signed [DW-1:0]   coef_rd, samp_rd;
  logic signed [ACCW-1:0] prod_ext;
  logic        [DW-1:0]   sat_val;

  assign coef_rd  = bank_sel ? bank1[tap] : bank0[tap];
  assign samp_rd  = dline[rd_ptr];
  // The signed product of two DW-bit values fits in ACCW bits, so forming it
  // directly at accumulator width keeps the sign extension exact.
  assign prod_ext = ACCW'(coef_rd) * ACCW'(samp_rd);

  always_comb begin
    // NOTE: every variable written here gets a default first; otherwise a path
    // that skips the assignment infers a latch.
    sat_val = acc[DW-1:0];
    if (acc > SAT_MAX)      sat_val = SAT_MAX[DW-1:0];
    else if (acc < SAT_MIN) sat_val = SAT_MIN[DW-1:0];
  end

  // FSM: state register plus next-state logic
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_hs) state_nxt = MAC;
      MAC:     if (tap == LAST) state_nxt = ROUND;
      ROUND:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Coefficient load control and bank selection
  always_ff @(posedge clk or negedge rst_int_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values no matter which order the blocks run in.
    if (!rst_int_n) begin
      bank_sel     <= 1'b0;
      swap_pending <= 1'b0;
      ld_idx       <= '0;
      coef_err     <= 1'b0;
    end else begin
      coef_err <= coef_bad;
      if (do_swap) begin
        bank_sel     <= ~bank_sel;
        swap_pending <= 1'b0;
        ld_idx       <= '0;
      end else if (coef_hs) begin
        if (coef_bad) begin
          ld_idx <= '0;
        end else if (coef_done) begin
          // The index cannot advance past the last tap. It stays at zero until
          // the swap, and coef_ready stays low in the meantime.
          swap_pending <= 1'b1;
          ld_idx       <= '0;
        end else begin
          ld_idx <= ld_idx + IW'(1);
        end
      end
    end
  end

  // Coefficient banks and sample delay line
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      // NOTE: these memories are cleared in reset on purpose, so the output is
      // exactly zero until a bank is loaded. Most RAM arrays are left
      // unreset so they can map onto block memory.
      for (int i = 0; i < NTAPS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
        dline[i] <= '0;
      end
    end else begin
      if (coef_hs) begin
        if (bank_sel) bank0[ld_idx] <= coef_data;
        else          bank1[ld_idx] <= coef_data;
      end
      if (in_hs) dline[wr_ptr] <= in_data;
    end
  end

  // Accumulate, round and output
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      acc       <= '0;
      tap       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_hs) begin
            acc    <= '0;
            tap    <= '0;
            rd_ptr <= wr_ptr;
          end
        end
        MAC: begin
          acc    <= acc + prod_ext;
          tap    <= tap + IW'(1);
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - IW'(1);
        end
        ROUND: begin
          acc <= (acc + RND_BIAS) >>> (DW - 1);
        end
        OUT: begin
          out_valid <= 1'b1;
          out_data  <= sat_val;
          wr_ptr    <= (wr_ptr == LAST) ? '0 : wr_ptr + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_bank_fir.sv
// -----------------------------------------------------------------------------
// tb_coeff_bank_fir
//
// Directed bench for coeff_bank_fir with NTAPS=13, DW=16, ACCW=40. The bench
// keeps its own reference state: the active and pending coefficient sets, and
// a sample history with the newest sample at index 0. Expected results come
// from hand-derived constants or from a direct convolution over that state.
// -----------------------------------------------------------------------------
module tb_coeff_bank_fir;

  localparam int NT   = 13;
  localparam int DW   = 16;
  localparam int ACCW = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          coef_valid = 1'b0;
  logic [DW-1:0] coef_data = '0;
  logic          coef_last = 1'b0;
  logic          coef_ready;
  logic          coef_err;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          bank_sel;

  coeff_bank_fir #(.NTAPS(NT), .DW(DW), .ACCW(ACCW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_last  (coef_last),
    .coef_ready (coef_ready),
    .coef_err   (coef_err),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .bank_sel   (bank_sel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int err_cnt = 0;
  int ov_cnt = 0;

  // Edge counters for coef_err and out_valid, sampled on the falling edge.
  always @(negedge clk) begin
    if (coef_err)  err_cnt = err_cnt + 1;
    if (out_valid) ov_cnt  = ov_cnt + 1;
  end

  // Reference state
  logic signed [DW-1:0] act    [NT];
  logic signed [DW-1:0] nxt    [NT];
  logic signed [DW-1:0] hist   [NT];
  logic signed [DW-1:0] ld_buf [NT];
  bit                   pend;
  bit                   mbank;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      act[i]  = '0;
      nxt[i]  = '0;
      hist[i] = '0;
    end
    pend  = 1'b0;
    mbank = 1'b0;
  endtask

  // A pending set becomes active before the next sample is taken.
  task automatic model_push(input logic [DW-1:0] d);
    if (pend) begin
      act   = nxt;
      pend  = 1'b0;
      mbank = ~mbank;
    end
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
  endtask

  function automatic logic [DW-1:0] model_out();
    longint acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(act[k]) * longint'(hist[k]);
    acc = (acc + 16384) >>> 15;
    if (acc > 32767)  return 16'h7fff;
    if (acc < -32768) return 16'h8000;
    return acc[15:0];
  endfunction

  // All drivers run on the falling edge. A handshake takes effect on the
  // following rising edge.
  task automatic send_coef(input logic [DW-1:0] d, input logic last);
    int n = 0;
    coef_valid = 1'b1;
    coef_data  = d;
    coef_last  = last;
    while (!coef_ready && n < 4 * NT) begin
      @(negedge clk);
      n++;
    end
    check("coef_ready_wait", coef_ready, 1);
    @(negedge clk);
  endtask

  task automatic load_set();
    for (int i = 0; i < NT; i++) send_coef(ld_buf[i], (i == NT - 1));
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    nxt  = ld_buf;
    pend = 1'b1;
  endtask

  task automatic send_sample(input logic [DW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 4 * NT) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts clock cycles from the handshake edge until out_valid is seen.
  task automatic wait_out(output logic [DW-1:0] q, output int lat, output logic bs);
    lat = 0;
    while (!out_valid && lat < 4 * NT) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
    q  = out_data;
    bs = bank_sel;
  endtask

  task automatic run_sample(input string tag, input logic [DW-1:0] d,
                            input bit use_exp, input logic [DW-1:0] exp);
    logic [DW-1:0] q, e;
    int            lat;
    logic          bs;
    model_push(d);
    e = use_exp ? exp : model_out();
    send_sample(d);
    wait_out(q, lat, bs);
    check(tag, q, e);
    check("latency", lat, NT + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] q, e;
    int            lat, e0, o0;
    logic          bs;

    model_reset();

    // Reset state, checked while reset is still asserted
    repeat (3) @(negedge clk);
    check("rst_bank_sel",   bank_sel,   0);
    check("rst_in_ready",   in_ready,   1);
    check("rst_coef_ready", coef_ready, 1);
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_data",   out_data,   0);
    check("rst_coef_err",   coef_err,   0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Zeroed banks: an impulse before any load gives 0
    run_sample("unloaded_impulse", 16'h7fff, 1'b1, 16'h0000);
    for (int i = 0; i < NT; i++) run_sample("flush", 16'h0000, 1'b0, 16'h0000);

    // Impulse response with c[k] = k*100: round(32767*c/32768) equals c here
    for (int i = 0; i < NT; i++) ld_buf[i] = 16'(i * 100);
    load_set();
    for (int n = 0; n < NT; n++)
      run_sample("impulse", (n == 0) ? 16'h7fff : 16'h0000, 1'b1, 16'(n * 100));
    check("bank_after_load", bank_sel, 1);

    // Saturation: positive and negative rails once the delay line is full
    for (int i = 0; i < NT; i++) ld_buf[i] = 16'h7fff;
    load_set();
    for (int n = 0; n < NT - 1; n++) run_sample("sat_pos_fill", 16'h7fff, 1'b0, 16'h0000);
    run_sample("sat_pos", 16'h7fff, 1'b1, 16'h7fff);
    for (int n = 0; n < NT - 1; n++) run_sample("sat_neg_fill", 16'h8000, 1'b0, 16'h0000);
    run_sample("sat_neg", 16'h8000, 1'b1, 16'h8000);

    // Swap timing: finish a set during MAC
    for (int i = 0; i < NT; i++) ld_buf[i] = 16'((i - 6) * 1500);
    model_push(16'h1234);
    e = model_out();
    fork
      begin
        send_sample(16'h1234);
        wait_out(q, lat, bs);
      end
      load_set();
    join
    check("swap_old_bank_data", q, e);
    check("swap_latency", lat, NT + 2);
    check("swap_bank_at_out", bs, 0);
    @(negedge clk);
    check("swap_bank_toggled", bank_sel, 1);
    run_sample("swap_new_bank", 16'h0c00, 1'b0, 16'h0000);

    // Malformed set: coef_last at index 5
    e0 = err_cnt;
    for (int i = 0; i <= 5; i++) send_coef(16'h5555, (i == 5));
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("malformed_err_pulses", err_cnt - e0, 1);
    check("malformed_bank_sel", bank_sel, mbank);
    check("malformed_coef_ready", coef_ready, 1);
    for (int i = 0; i < NT; i++) ld_buf[i] = 16'((i + 1) * 700 - 4000);
    load_set();
    check("reload_no_err", err_cnt - e0, 1);
    run_sample("reload_first", 16'h2000, 1'b0, 16'h0000);
    run_sample("reload_second", 16'hf000, 1'b0, 16'h0000);

    // Wrap-around with random coefficients and samples against the model
    for (int i = 0; i < NT; i++) ld_buf[i] = 16'($urandom);
    load_set();
    for (int n = 0; n < 3 * NT; n++) run_sample("wrap", 16'($urandom), 1'b0, 16'h0000);
    check("bank_before_reset", bank_sel, 1);

    // Reset during MAC cycle 10: no result, clean state afterwards
    send_sample(16'h4000);
    repeat (10) @(negedge clk);
    o0 = ov_cnt;
    rst_n = 1'b0;
    repeat (NT + 6) @(negedge clk);
    check("midrst_no_out_valid", ov_cnt - o0, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_bank_sel", bank_sel, 0);
    model_reset();
    run_sample("midrst_impulse", 16'h7fff, 1'b1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
